// File: rtl/imem_byte_loader.sv
// Streams 32-bit instruction words into a byte-wide instruction memory,
// little-endian, one byte per cycle from BASE_ADDR upward.
module imem_byte_loader #(
   parameter int unsigned              ADDR_W    = 64,
   parameter int unsigned              MEM_BYTES = 16,
   parameter logic [ADDR_W-1:0]        BASE_ADDR = {ADDR_W{1'b0}},
   localparam int unsigned             CNT_W     = $clog2(MEM_BYTES/4) + 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              word_valid,
   input  logic [31:0]       word_data,
   input  logic              word_last,
   output logic              word_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [CNT_W-1:0]  words_loaded
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] END_ADDR = BASE_ADDR + ADDR_W'(MEM_BYTES);

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  ptr_q, ptr_d;
   logic [1:0]         idx_q, idx_d;
   logic [31:0]        word_q, word_d;
   logic               last_q, last_d;
   logic [CNT_W-1:0]   words_q, words_d;
   logic               ovf_q, ovf_d;

   function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] idx);
      case (idx)
         2'd0:    byte_sel = w[7:0];
         2'd1:    byte_sel = w[15:8];
         2'd2:    byte_sel = w[23:16];
         2'd3:    byte_sel = w[31:24];
         default: byte_sel = 8'h00;
      endcase
   endfunction

   // State and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         ptr_q   <= BASE_ADDR;
         idx_q   <= 2'd0;
         word_q  <= 32'h0000_0000;
         last_q  <= 1'b0;
         words_q <= {CNT_W{1'b0}};
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         last_q  <= last_d;
         words_q <= words_d;
         ovf_q   <= ovf_d;
      end
   end

   // Next-state logic; start overrides everything, including a word offered the same cycle
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      word_d  = word_q;
      last_d  = last_q;
      words_d = words_q;
      ovf_d   = ovf_q;
      if (start) begin
         state_d = S_ARMED;
         ptr_d   = BASE_ADDR;
         idx_d   = 2'd0;
         words_d = {CNT_W{1'b0}};
         ovf_d   = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_IDLE;
            end
            S_ARMED: begin
               if (word_valid) begin
                  word_d  = word_data;
                  last_d  = word_last;
                  idx_d   = 2'd0;
                  state_d = S_WRITE;
               end else begin
                  state_d = S_ARMED;
               end
            end
            S_WRITE: begin
               ptr_d = ptr_q + ADDR_ONE;
               idx_d = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  words_d = words_q + CNT_ONE;
                  // An explicit last word takes precedence over the full-memory check
                  if (last_q) begin
                     state_d = S_DONE;
                  end else if (ptr_d == END_ADDR) begin
                     state_d = S_DONE;
                     ovf_d   = 1'b1;
                  end else begin
                     state_d = S_ARMED;
                  end
               end else begin
                  state_d = S_WRITE;
               end
            end
            S_DONE: begin
               state_d = S_DONE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // Outputs decode registered state only, so reset clears them asynchronously
   always_comb begin
      word_ready   = (state_q == S_ARMED);
      busy         = (state_q == S_ARMED) || (state_q == S_WRITE);
      mem_we       = (state_q == S_WRITE);
      done         = (state_q == S_DONE);
      overflow     = ovf_q;
      words_loaded = words_q;
      if (state_q == S_WRITE) begin
         mem_addr  = ptr_q;
         mem_wdata = byte_sel(word_q, idx_q);
      end else begin
         mem_addr  = {ADDR_W{1'b0}};
         mem_wdata = 8'h00;
      end
   end

endmodule

// File: tb/tb_imem_byte_loader.sv
// Self-checking bench for imem_byte_loader: expected byte writes are queued as
// words are driven and matched against writes captured from the memory port.
module tb_imem_byte_loader;

   localparam int ADDR_W = 64;

   logic              clk;
   logic              reset;
   logic              start;
   logic              word_valid;
   logic [31:0]       word_data;
   logic              word_last;
   logic              word_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              busy;
   logic              done;
   logic              overflow;
   logic [2:0]        words_loaded;

   int n_checks = 0;
   int n_fail   = 0;

   logic [71:0] exp_q[$];
   logic [71:0] obs_q[$];

   imem_byte_loader #(.ADDR_W(64), .MEM_BYTES(16), .BASE_ADDR(64'd0)) dut (
      .clk(clk), .reset(reset), .start(start), .word_valid(word_valid),
      .word_data(word_data), .word_last(word_last), .word_ready(word_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy),
      .done(done), .overflow(overflow), .words_loaded(words_loaded)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Capture every byte write mid-cycle
   always @(negedge clk) begin
      if (mem_we === 1'b1) obs_q.push_back({mem_addr, mem_wdata});
   end

   task automatic push_exp(input logic [31:0] w, input logic [63:0] base, input int nbytes);
      for (int b = 0; b < nbytes; b++) begin
         logic [63:0] a;
         logic [7:0]  d;
         a = base + 64'(b);
         d = w[8*b +: 8];
         exp_q.push_back({a, d});
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] d, input logic l);
      bit ok;
      ok = 1'b0;
      word_valid = 1'b1;
      word_data  = d;
      word_last  = l;
      for (int i = 0; i < 30 && !ok; i++) begin
         if (word_ready === 1'b1) ok = 1'b1;
         @(posedge clk); #1;
      end
      word_valid = 1'b0;
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL send_timeout: word %h not accepted, ready=%b required 1", d, word_ready);
      end
   endtask

   task automatic wait_done();
      int i;
      i = 0;
      while (done !== 1'b1 && i < 60) begin
         @(posedge clk); #1;
         i++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; word_valid = 1'b1;
      word_data = 32'hDEAD_BEEF; word_last = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if ({word_ready, mem_we, busy, done, overflow} !== 5'b0 || words_loaded !== 3'd0 ||
          mem_addr !== 64'd0 || mem_wdata !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: rdy=%b we=%b busy=%b done=%b ovf=%b wl=%0d addr=%h data=%h, required all 0",
                  word_ready, mem_we, busy, done, overflow, words_loaded, mem_addr, mem_wdata);
      end
      word_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (busy !== 1'b0 || word_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset: busy=%b ready=%b required 0 0", busy, word_ready);
      end
      pulse_start();
      n_checks++;
      if (word_ready !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL armed_after_start: ready=%b busy=%b required 1 1", word_ready, busy);
      end
   endtask

   task automatic test_single_word();
      logic [31:0] w;
      logic [71:0] e, o;
      w = 32'h0285_3483;
      pulse_start();
      push_exp(w, 64'd0, 4);
      send_word(w, 1'b0);
      for (int k = 0; k < 4; k++) begin
         logic [7:0] eb;
         eb = w[8*k +: 8];
         n_checks++;
         if (mem_we !== 1'b1 || mem_addr !== 64'(k) || mem_wdata !== eb || word_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL single_cycle%0d: we=%b addr=%h data=%h rdy=%b, required 1 %h %h 0",
                     k, mem_we, mem_addr, mem_wdata, word_ready, 64'(k), eb);
         end
         @(posedge clk); #1;
      end
      n_checks++;
      if (word_ready !== 1'b1 || mem_we !== 1'b0 || words_loaded !== 3'd1) begin
         n_fail++;
         $display("FAIL single_ready_again: rdy=%b we=%b wl=%0d, required 1 0 1", word_ready, mem_we, words_loaded);
      end
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL single_count: %0d writes seen, required %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL single_write: got addr %h data %h, required addr %h data %h", o[71:8], o[7:0], e[71:8], e[7:0]);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_multi_word();
      logic [31:0] w;
      logic [71:0] e, o;
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         w = $urandom;
         push_exp(w, 64'(4*i), 4);
         send_word(w, (i == 3));
      end
      wait_done();
      n_checks++;
      if (done !== 1'b1 || overflow !== 1'b0 || words_loaded !== 3'd4 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL multi_status: done=%b ovf=%b wl=%0d busy=%b, required 1 0 4 0", done, overflow, words_loaded, busy);
      end
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL multi_count: %0d writes seen, required %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL multi_write: got addr %h data %h, required addr %h data %h", o[71:8], o[7:0], e[71:8], e[7:0]);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_overflow();
      logic [31:0] w;
      logic [71:0] e, o;
      bit ready_seen;
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         w = 32'h1111_1111 * (i + 1);
         push_exp(w, 64'(4*i), 4);
         send_word(w, 1'b0);
      end
      wait_done();
      n_checks++;
      if (done !== 1'b1 || overflow !== 1'b1 || words_loaded !== 3'd4) begin
         n_fail++;
         $display("FAIL ovf_status: done=%b ovf=%b wl=%0d, required 1 1 4", done, overflow, words_loaded);
      end
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL ovf_count: %0d writes seen, required %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL ovf_write: got addr %h data %h, required addr %h data %h", o[71:8], o[7:0], e[71:8], e[7:0]);
         end
      end
      exp_q.delete(); obs_q.delete();
      ready_seen = 1'b0;
      word_valid = 1'b1; word_data = 32'hCAFE_F00D; word_last = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (word_ready !== 1'b0) ready_seen = 1'b1;
         @(posedge clk); #1;
      end
      word_valid = 1'b0;
      n_checks++;
      if (ready_seen || obs_q.size() != 0 || overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_refuse: ready_seen=%b extra_writes=%0d ovf=%b, required 0 0 1", ready_seen, obs_q.size(), overflow);
      end
      obs_q.delete();
   endtask

   task automatic test_start_abort();
      logic [31:0] wa, wb;
      logic [71:0] e, o;
      wa = 32'hA1B2_C3D4;
      wb = 32'h5566_7788;
      pulse_start();
      push_exp(wa, 64'd0, 2);
      send_word(wa, 1'b0);
      @(posedge clk); #1;
      n_checks++;
      if (mem_we !== 1'b1 || mem_addr !== 64'd1) begin
         n_fail++;
         $display("FAIL abort_setup: we=%b addr=%h, required 1 1", mem_we, mem_addr);
      end
      pulse_start();
      n_checks++;
      if (mem_we !== 1'b0 || word_ready !== 1'b1 || words_loaded !== 3'd0) begin
         n_fail++;
         $display("FAIL abort_state: we=%b rdy=%b wl=%0d, required 0 1 0", mem_we, word_ready, words_loaded);
      end
      push_exp(wb, 64'd0, 4);
      send_word(wb, 1'b1);
      wait_done();
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL abort_count: %0d writes seen, required %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL abort_write: got addr %h data %h, required addr %h data %h", o[71:8], o[7:0], e[71:8], e[7:0]);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   task automatic test_reset_mid_write();
      logic [31:0] w;
      logic [71:0] e, o;
      w = 32'h0BAD_F00D;
      pulse_start();
      push_exp(w, 64'd0, 1);
      send_word(w, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      n_checks++;
      if (mem_we !== 1'b0 || words_loaded !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_mid_async: we=%b wl=%0d, required 0 0", mem_we, words_loaded);
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || word_ready !== 1'b0 || mem_we !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_idle: done=%b busy=%b rdy=%b we=%b, required 0 0 0 0", done, busy, word_ready, mem_we);
      end
      n_checks++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL reset_mid_count: %0d writes seen, required %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front();
         n_checks++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL reset_mid_write: got addr %h data %h, required addr %h data %h", o[71:8], o[7:0], e[71:8], e[7:0]);
         end
      end
      exp_q.delete(); obs_q.delete();
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_multi_word();
      test_overflow();
      test_start_abort();
      test_reset_mid_write();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
